// File: rtl/glip_uart_pkg.sv
// Shared constants and types for the GLIP UART host transmit path.
package glip_uart_pkg;

    // Default link escape byte; a command is sent as ESC followed by its code.
    localparam logic [7:0] ESC_DEFAULT = 8'hFE;

    // 8N1 frame: start + 8 data + stop.
    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = 8;

    // Serializer state. IDLE is the only state in which new work is accepted.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/glip_uart_host_bitser.sv
// 8N1 bit serializer: loads one byte, shifts it out LSB-first with each bit
// held DIVISOR cycles, and pulses o_last_bit_done in the final stop-bit cycle
// so a follow-on byte can be loaded with no idle gap.
module glip_uart_host_bitser
    import glip_uart_pkg::*;
#(
    parameter int unsigned DIVISOR = 4
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       i_load,
    input  logic [7:0] i_byte,
    output logic       o_last_bit_done,
    output logic       o_tx,
    output tx_state_e  o_state
);

    localparam int DIV_W = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIVISOR - 1);
    localparam logic [2:0]       LAST_DATA = 3'(DATA_BITS - 1);

    tx_state_e        r_state;
    logic [DIV_W-1:0] r_div;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic             r_tx;
    logic             w_bit_end;

    assign w_bit_end       = (r_div == DIV_LAST);
    assign o_last_bit_done = (r_state == STOP) && w_bit_end;
    assign o_tx            = r_tx;
    assign o_state         = r_state;

    // Frame sequencer: divider, bit index, shift register and line register.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            if (r_state == IDLE) begin
                r_div <= '0;
            end else begin
                r_div <= w_bit_end ? '0 : r_div + DIV_W'(1);
            end

            case (r_state)
                IDLE: begin
                    if (i_load) begin
                        r_shift <= i_byte;
                        r_bit   <= '0;
                        r_tx    <= 1'b0;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_tx    <= r_shift[0];
                        r_shift <= {1'b0, r_shift[7:1]};
                        r_bit   <= '0;
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        if (r_bit == LAST_DATA) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_tx    <= r_shift[0];
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_bit   <= r_bit + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        // A chained byte starts its start bit right after this stop bit.
                        if (i_load) begin
                            r_shift <= i_byte;
                            r_bit   <= '0;
                            r_tx    <= 1'b0;
                            r_state <= START;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/glip_uart_host_tx.sv
// Host-side GLIP UART transmitter: escape encoding, credit flow control,
// CTS gating and 8N1 serialization at FREQ_CLK/BAUD.
//
// Handshake: a payload byte transfers in a cycle where in_valid & in_ready;
// a command transfers where cmd_valid & cmd_ready. Both readies are only
// high in IDLE with CTS asserted, and a pending command masks in_ready so
// commands win. Valid may be held across cycles until the transfer happens.
module glip_uart_host_tx
    import glip_uart_pkg::*;
#(
    // Must be overridden by the instantiator; DIVISOR = FREQ_CLK/BAUD must be >= 2.
    parameter int unsigned FREQ_CLK     = 0,
    parameter int unsigned BAUD         = 115200,
    parameter int          CREDIT_WIDTH = 12,
    parameter logic [7:0]  ESC          = ESC_DEFAULT
) (
    input  logic                    clk,
    input  logic                    nreset,
    input  logic [7:0]              in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [7:0]              cmd_code,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [CREDIT_WIDTH-1:0] credit_add,
    input  logic                    credit_add_valid,
    output logic [CREDIT_WIDTH-1:0] credit,
    output logic                    uart_tx,
    input  logic                    uart_cts_n,
    output logic                    busy,
    output logic                    error
);

    localparam int unsigned DIVISOR = FREQ_CLK / BAUD;

    logic                    r_cts_meta;
    logic                    r_cts_sync;
    logic                    r_pend_valid;
    logic [7:0]              r_pend_byte;
    logic [CREDIT_WIDTH-1:0] r_credit;
    logic                    r_error;

    tx_state_e               w_state;
    logic                    w_last_bit_done;
    logic                    w_cts_ok;
    logic                    w_idle;
    logic                    w_cmd_acc;
    logic                    w_data_acc;
    logic                    w_chain;
    logic                    w_load;
    logic [7:0]              w_load_byte;
    logic [CREDIT_WIDTH:0]   w_credit_sum;

    assign w_cts_ok   = ~r_cts_sync;
    assign w_idle     = (w_state == IDLE);
    assign cmd_ready  = w_idle & w_cts_ok;
    assign in_ready   = w_idle & w_cts_ok & (r_credit != '0) & ~cmd_valid;
    assign w_cmd_acc  = cmd_valid & cmd_ready;
    assign w_data_acc = in_valid & in_ready;
    assign w_chain    = w_last_bit_done & r_pend_valid;
    assign w_load     = w_cmd_acc | w_data_acc | w_chain;

    assign credit = r_credit;
    assign error  = r_error;
    assign busy   = ~w_idle;

    // CTS synchronizer; resets to "not clear" so nothing starts until the device allows it.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_cts_meta <= 1'b1;
            r_cts_sync <= 1'b1;
        end else begin
            r_cts_meta <= uart_cts_n;
            r_cts_sync <= r_cts_meta;
        end
    end

    // Byte handed to the serializer: chained second byte, command escape, or payload.
    always_comb begin
        w_load_byte = in_data;
        if (w_chain) begin
            w_load_byte = r_pend_byte;
        end else if (w_cmd_acc) begin
            w_load_byte = ESC;
        end
    end

    // Second byte of an escape pair, released at the end of the first frame.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_pend_valid <= 1'b0;
            r_pend_byte  <= '0;
        end else if (w_chain) begin
            r_pend_valid <= 1'b0;
        end else if (w_cmd_acc) begin
            r_pend_valid <= 1'b1;
            r_pend_byte  <= cmd_code;
        end else if (w_data_acc && (in_data == ESC)) begin
            r_pend_valid <= 1'b1;
            r_pend_byte  <= ESC;
        end
    end

    // Next credit value with one spare bit to detect overflow; cannot underflow
    // because a payload is only accepted with nonzero credit.
    always_comb begin
        w_credit_sum = {1'b0, r_credit};
        if (credit_add_valid) begin
            w_credit_sum = w_credit_sum + {1'b0, credit_add};
        end
        if (w_data_acc) begin
            w_credit_sum = w_credit_sum - (CREDIT_WIDTH+1)'(1);
        end
    end

    // Credit counter (saturating) and sticky error flag.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_credit <= '0;
            r_error  <= 1'b0;
        end else begin
            r_credit <= w_credit_sum[CREDIT_WIDTH] ? '1 : w_credit_sum[CREDIT_WIDTH-1:0];
            if (w_credit_sum[CREDIT_WIDTH] || (w_cmd_acc && (cmd_code == ESC))) begin
                r_error <= 1'b1;
            end
        end
    end

    glip_uart_host_bitser #(
        .DIVISOR (DIVISOR)
    ) u_bitser (
        .clk             (clk),
        .nreset          (nreset),
        .i_load          (w_load),
        .i_byte          (w_load_byte),
        .o_last_bit_done (w_last_bit_done),
        .o_tx            (uart_tx),
        .o_state         (w_state)
    );

endmodule

// File: tb/tb_glip_uart_host_tx.sv
// Bench for glip_uart_host_tx at DIVISOR=4, CREDIT_WIDTH=12.
module tb_glip_uart_host_tx;

  localparam int CW = 12;
  localparam logic [7:0] ESC = 8'hFE;

  logic          clk;
  logic          nreset;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    cmd_code;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [CW-1:0] credit_add;
  logic          credit_add_valid;
  logic [CW-1:0] credit;
  logic          uart_tx;
  logic          uart_cts_n;
  logic          busy;
  logic          error;

  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  logic rst_seen = 1'b0;

  glip_uart_host_tx #(
    .FREQ_CLK     (4),
    .BAUD         (1),
    .CREDIT_WIDTH (CW),
    .ESC          (ESC)
  ) dut (
    .clk              (clk),
    .nreset           (nreset),
    .in_data          (in_data),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .cmd_code         (cmd_code),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .credit_add       (credit_add),
    .credit_add_valid (credit_add_valid),
    .credit           (credit),
    .uart_tx          (uart_tx),
    .uart_cts_n       (uart_cts_n),
    .busy             (busy),
    .error            (error)
  );

  // clock / reset-watch
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge nreset) rst_seen = 1'b1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got=running required=done");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks (called at posedge+1, return at posedge+1)
  task automatic add_credit(input logic [CW-1:0] n);
    credit_add = n;
    credit_add_valid = 1'b1;
    @(posedge clk); #1;
    credit_add_valid = 1'b0;
    credit_add = '0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int budget, output int waited);
    logic ok;
    ok = 1'b0;
    waited = 0;
    in_data = b;
    in_valid = 1'b1;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      waited++;
      if (in_ready) ok = 1'b1;
    end
    if (!ok) begin
      check("data_accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_q.push_back(b);
    if (b == ESC) exp_q.push_back(ESC);
  endtask

  task automatic send_cmd(input logic [7:0] c, input int budget);
    logic ok;
    ok = 1'b0;
    cmd_code = c;
    cmd_valid = 1'b1;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1'b1;
    end
    if (!ok) begin
      check("cmd_accept_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    exp_q.push_back(ESC);
    exp_q.push_back(c);
  endtask

  task automatic apply_reset();
    nreset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_tx", uart_tx, 1);
    check("rst_in_ready", in_ready, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_credit", credit, 0);
    check("rst_busy", busy, 0);
    check("rst_error", error, 0);
    @(posedge clk); #1;
    nreset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // scoreboard monitor: decode 40-cycle frames, pop and compare
  initial begin
    logic s [40];
    logic hold_ok;
    logic [7:0] got;
    forever begin
      @(negedge clk);
      if (nreset && !uart_tx) begin
        rst_seen = 1'b0;
        s[0] = uart_tx;
        for (int k = 1; k < 40; k++) begin
          @(negedge clk);
          s[k] = uart_tx;
        end
        if (!rst_seen) begin
          hold_ok = 1'b1;
          for (int b = 0; b < 10; b++)
            for (int j = 1; j < 4; j++)
              if (s[4*b+j] !== s[4*b]) hold_ok = 1'b0;
          for (int i = 0; i < 8; i++) got[i] = s[4 + 4*i];
          check("frame_bit_hold", hold_ok, 1);
          check("frame_stop", s[36], 1);
          if (exp_q.size() == 0) check("frame_unexpected", {24'd0, got}, 32'hFFFF_FFFF);
          else check("frame_byte", got, exp_q.pop_front());
        end
      end
    end
  end

  // main sequence
  initial begin
    int w;
    int zeros;
    nreset = 1'b0;
    in_data = '0;
    in_valid = 1'b0;
    cmd_code = '0;
    cmd_valid = 1'b0;
    credit_add = '0;
    credit_add_valid = 1'b0;
    uart_cts_n = 1'b0;
    apply_reset();

    // 1: credit 3, send 0x55
    add_credit(12'd3);
    @(negedge clk);
    check("t1_ready_after_credit", in_ready, 1);
    check("t1_credit3", credit, 3);
    @(posedge clk); #1;
    send_byte(8'h55, 5, w);
    @(negedge clk);
    check("t1_start_bit", uart_tx, 0);
    check("t1_ready_low", in_ready, 0);
    check("t1_busy", busy, 1);
    repeat (39) @(negedge clk);
    check("t1_ready_t40", in_ready, 0);
    @(negedge clk);
    check("t1_ready_t41", in_ready, 1);
    check("t1_credit2", credit, 2);

    // 2: ESC payload with last credit -> two chained frames
    @(posedge clk); #1;
    send_byte(8'hA3, 5, w);
    repeat (41) @(negedge clk);
    check("t2_credit1", credit, 1);
    @(posedge clk); #1;
    send_byte(ESC, 5, w);
    @(negedge clk);
    repeat (39) @(negedge clk);
    check("t2_stop_t40", uart_tx, 1);
    @(negedge clk);
    check("t2_no_gap_t41", uart_tx, 0);
    check("t2_busy_t41", busy, 1);
    repeat (39) @(negedge clk);
    check("t2_busy_t80", busy, 1);
    @(negedge clk);
    check("t2_idle_t81", busy, 0);
    check("t2_credit0", credit, 0);
    check("t2_ready_no_credit", in_ready, 0);

    // 3: payload stalls at zero credit, command goes through
    @(posedge clk); #1;
    in_data = 8'h77;
    in_valid = 1'b1;
    repeat (5) @(negedge clk);
    check("t3_stall", in_ready, 0);
    @(posedge clk); #1;
    send_cmd(8'h01, 5);
    in_valid = 1'b1;
    @(negedge clk);
    check("t3_cmd_ready_t1", cmd_ready, 0);
    repeat (79) @(negedge clk);
    check("t3_cmd_ready_t80", cmd_ready, 0);
    @(negedge clk);
    check("t3_cmd_ready_t81", cmd_ready, 1);
    check("t3_credit0", credit, 0);
    check("t3_still_stalled", in_ready, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;

    // 4: CTS gating
    uart_cts_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    add_credit(12'd5);
    in_data = 8'h3C;
    in_valid = 1'b1;
    zeros = 0;
    repeat (100) begin
      @(negedge clk);
      if (!uart_tx || in_ready) zeros++;
    end
    check("t4_no_start_cts_high", zeros, 0);
    @(posedge clk); #1;
    uart_cts_n = 1'b0;
    send_byte(8'h3C, 10, w);
    check("t4_cts_latency_le3", (w <= 3), 1);
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    uart_cts_n = 1'b1;
    repeat (30) @(negedge clk);
    check("t4_busy_t40", busy, 1);
    @(negedge clk);
    check("t4_idle_t41", busy, 0);
    check("t4_ready_cts_high", in_ready, 0);
    check("t4_credit4", credit, 4);
    @(posedge clk); #1;
    uart_cts_n = 1'b0;

    // 5: saturation sets sticky error
    add_credit(12'd4091);
    @(negedge clk);
    check("t5_credit_max", credit, 4095);
    check("t5_no_error", error, 0);
    @(posedge clk); #1;
    add_credit(12'd2);
    @(negedge clk);
    check("t5_credit_sat", credit, 4095);
    check("t5_error_set", error, 1);
    repeat (20) @(negedge clk);
    check("t5_error_sticky", error, 1);
    @(posedge clk); #1;

    // 6: simultaneous accept + credit strobe, then reset mid-frame
    apply_reset();
    add_credit(12'd1);
    in_data = 8'h81;
    in_valid = 1'b1;
    credit_add = 12'd5;
    credit_add_valid = 1'b1;
    @(negedge clk);
    check("t6_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    credit_add_valid = 1'b0;
    credit_add = '0;
    @(negedge clk);
    check("t6_credit_sim", credit, 5);
    repeat (21) @(negedge clk);
    check("t6_bit4_low", uart_tx, 0);
    #2;
    nreset = 1'b0;
    #1;
    check("t6_async_tx", uart_tx, 1);
    check("t6_async_busy", busy, 0);
    check("t6_async_credit", credit, 0);
    check("t6_async_error", error, 0);
    repeat (2) @(posedge clk);
    #1;
    nreset = 1'b1;
    repeat (45) @(posedge clk);
    #1;
    check("t6_no_leftover", uart_tx, 1);

    // 7: command equal to ESC sets error, sent as ESC ESC
    send_cmd(ESC, 5);
    @(negedge clk);
    check("t7_error", error, 1);
    check("t7_credit0", credit, 0);
    repeat (80) @(negedge clk);
    check("t7_idle", busy, 0);

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
